// File: rtl/gate_exerciser.sv
// gate_exerciser: walks a/b through 00,01,10,11 for ROUNDS passes and checks the
// seven gate-cell outputs against their truth table after SETTLE_CYCLES cycles.
module gate_exerciser #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ROUNDS        = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic [6:0] y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [1:0] fail_vec,
   output logic [6:0] fail_mask
);
   localparam int CW = $clog2(SETTLE_CYCLES) + 1;
   localparam int RW = $clog2(ROUNDS) + 1;
   typedef enum logic [1:0] {IDLE, SETTLE, FINISH} state_t;
   state_t        state_q, state_d;
   logic [1:0]    vec_q, vec_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] round_q, round_d;
   logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [7:0]    err_q, err_d;
   logic [1:0]    fail_vec_q, fail_vec_d;
   logic [6:0]    fail_mask_q, fail_mask_d;
   logic [6:0]    exp_y;
   logic          sample, mism, last;
   always_comb begin
      exp_y       = vec_q == 2'd0 ? 7'h5C : vec_q == 2'd1 ? 7'h2E : vec_q == 2'd2 ? 7'h2A : 7'h43;
      sample      = state_q == SETTLE && cnt_q == CW'(SETTLE_CYCLES - 1);
      mism        = sample && y != exp_y;
      last        = vec_q == 2'd3 && round_q == RW'(ROUNDS - 1);
      state_d     = state_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      round_d     = round_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_d       = err_q;
      fail_vec_d  = fail_vec_q;
      fail_mask_d = fail_mask_q;
      case (state_q)
         IDLE: if (start) begin
            state_d     = SETTLE;
            vec_d       = 2'd0;
            cnt_d       = '0;
            round_d     = '0;
            busy_d      = 1'b1;
            pass_d      = 1'b0;
            err_d       = 8'd0;
            fail_vec_d  = 2'd0;
            fail_mask_d = 7'd0;
         end
         SETTLE: begin
            cnt_d = sample ? '0 : cnt_q + 1'b1;
            // a zero count doubles as "no mismatch yet" since it saturates rather than wraps
            if (mism) begin
               err_d = err_q == 8'hFF ? err_q : err_q + 8'd1;
               if (err_q == 8'd0) begin
                  fail_vec_d  = vec_q;
                  fail_mask_d = exp_y ^ y;
               end
            end
            if (sample && last) begin
               state_d = FINISH;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = err_q == 8'd0 && !mism;
            end else if (sample) begin
               vec_d   = vec_q + 2'd1;
               round_d = vec_q == 2'd3 ? round_q + 1'b1 : round_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= 2'd0;
         cnt_q       <= '0;
         round_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_q       <= 8'd0;
         fail_vec_q  <= 2'd0;
         fail_mask_q <= 7'd0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         round_q     <= round_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_q       <= err_d;
         fail_vec_q  <= fail_vec_d;
         fail_mask_q <= fail_mask_d;
      end
   end
   assign a         = vec_q[1];
   assign b         = vec_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_vec_q;
   assign fail_mask = fail_mask_q;
endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: four exerciser instances with different settle/round settings,
// each driving a behavioural gate cell with injectable stuck-at, flip and lag faults.
module tb_gate_exerciser;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] start_s = 4'd0;
   logic [3:0] a_s, b_s, busy_s, done_s, pass_s;
   logic [3:0][6:0] y_s, ylag_s, fm_s;
   logic [3:0][7:0] err_s;
   logic [3:0][1:0] fv_s;
   logic [6:0] xm [4][4];
   logic [6:0] s0 [4];
   logic [6:0] s1 [4];
   logic [3:0] lag;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   function automatic int s_of(input int i);
      return (i % 2 == 1) ? 1 : 2;
   endfunction
   function automatic int r_of(input int i);
      return i == 2 ? 3 : (i == 3 ? 70 : 1);
   endfunction
   function automatic logic [6:0] truth(input logic [1:0] v);
      logic x, z;
      x = v[1];
      z = v[0];
      return {~(x ^ z), x ^ z, ~(x | z), ~(x & z), ~x, x | z, x & z};
   endfunction

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         gate_exerciser #(.SETTLE_CYCLES(g % 2 == 1 ? 1 : 2), .ROUNDS(g == 2 ? 3 : (g == 3 ? 70 : 1))) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_s[g]), .a(a_s[g]), .b(b_s[g]), .y(y_s[g]),
            .busy(busy_s[g]), .done(done_s[g]), .pass(pass_s[g]), .err_count(err_s[g]),
            .fail_vec(fv_s[g]), .fail_mask(fm_s[g]));
      end
   endgenerate

   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++) ylag_s[i] <= truth({a_s[i], b_s[i]});
   always_comb
      for (int i = 0; i < 4; i++)
         y_s[i] = lag[i] ? ylag_s[i] : ((truth({a_s[i], b_s[i]}) ^ xm[i][{a_s[i], b_s[i]}]) | s1[i]) & ~s0[i];

   task automatic clear_faults();
      lag = 4'd0;
      for (int i = 0; i < 4; i++) begin
         s0[i] = 7'd0;
         s1[i] = 7'd0;
         for (int v = 0; v < 4; v++) xm[i][v] = 7'd0;
      end
   endtask

   // Expected run outcome derived from the cell's fault settings and the gate truth table
   task automatic model(input int i, output int e, output logic [1:0] fv, output logic [6:0] fm);
      logic [6:0] obs;
      e = 0;
      fv = 2'd0;
      fm = 7'd0;
      for (int r = 0; r < r_of(i); r++)
         for (int v = 0; v < 4; v++) begin
            obs = ((truth(2'(v)) ^ xm[i][v]) | s1[i]) & ~s0[i];
            if (obs != truth(2'(v))) begin
               if (e == 0) begin
                  fv = 2'(v);
                  fm = truth(2'(v)) ^ obs;
               end
               e++;
            end
         end
      if (e > 255) e = 255;
   endtask

   // n = negedge index after the start edge at which done is seen (-1 if never)
   task automatic run(input int i, input bit repulse, output int n_done, output bit seq_ok);
      int s, lim;
      s = s_of(i);
      lim = 4 * r_of(i) * s + 10;
      seq_ok = 1'b1;
      n_done = -1;
      @(negedge clk) start_s[i] = 1'b1;
      @(posedge clk);
      #1 start_s[i] = 1'b0;
      for (int n = 1; n <= lim; n++) begin
         @(negedge clk);
         if (done_s[i]) begin
            n_done = n;
            if (busy_s[i]) seq_ok = 1'b0;
            break;
         end
         if (!busy_s[i] || {a_s[i], b_s[i]} != 2'(((n - 1) / s) % 4)) seq_ok = 1'b0;
         if (repulse) start_s[i] = (n == 3);
      end
      start_s[i] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({a_s[i], b_s[i], busy_s[i], done_s[i], pass_s[i], err_s[i], fv_s[i], fm_s[i]} !== 23'd0) begin
            errors++;
            $display("FAIL reset[%0d]: got %h expected 0", i,
                     {a_s[i], b_s[i], busy_s[i], done_s[i], pass_s[i], err_s[i], fv_s[i], fm_s[i]});
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_golden();
      int n;
      bit ok;
      clear_faults();
      for (int i = 0; i < 3; i += 2) begin
         run(i, 1'b0, n, ok);
         checks++;
         if (n !== 4 * r_of(i) * s_of(i) + 1 || !ok) begin
            errors++;
            $display("FAIL golden_timing[%0d]: done at %0d seq_ok %0d expected %0d 1", i, n, ok, 4 * r_of(i) * s_of(i) + 1);
         end
         checks++;
         if ({pass_s[i], err_s[i], fv_s[i], fm_s[i]} !== {1'b1, 17'd0}) begin
            errors++;
            $display("FAIL golden_result[%0d]: pass %0d err %0d fv %0h fm %0h expected 1 0 0 0", i, pass_s[i], err_s[i], fv_s[i], fm_s[i]);
         end
      end
   endtask

   task automatic test_xor_stuck();
      int n;
      bit ok;
      clear_faults();
      s0[0] = 7'h20;
      run(0, 1'b0, n, ok);
      checks++;
      if ({pass_s[0], err_s[0], fv_s[0], fm_s[0]} !== {1'b0, 8'd2, 2'b01, 7'h20}) begin
         errors++;
         $display("FAIL xor_stuck: pass %0d err %0d fv %0h fm %0h expected 0 2 1 20", pass_s[0], err_s[0], fv_s[0], fm_s[0]);
      end
   endtask

   task automatic test_lag();
      int n;
      bit ok;
      clear_faults();
      lag = 4'b0011;
      run(0, 1'b0, n, ok);
      checks++;
      if ({pass_s[0], err_s[0]} !== {1'b1, 8'd0}) begin
         errors++;
         $display("FAIL lag_settle2: pass %0d err %0d expected 1 0", pass_s[0], err_s[0]);
      end
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      run(1, 1'b0, n, ok);
      checks++;
      if (n !== 5 || {pass_s[1], err_s[1], fv_s[1], fm_s[1]} !== {1'b0, 8'd3, 2'b01, 7'h72}) begin
         errors++;
         $display("FAIL lag_settle1: done %0d pass %0d err %0d fv %0h fm %0h expected 5 0 3 1 72", n, pass_s[1], err_s[1], fv_s[1], fm_s[1]);
      end
   endtask

   task automatic test_round_stuck();
      int n;
      bit ok;
      clear_faults();
      s1[2] = 7'h01;
      run(2, 1'b0, n, ok);
      checks++;
      if (n !== 25 || !ok || {pass_s[2], err_s[2], fv_s[2], fm_s[2]} !== {1'b0, 8'd9, 2'b00, 7'h01}) begin
         errors++;
         $display("FAIL rounds_and_stuck1: done %0d seq %0d pass %0d err %0d fv %0h fm %0h expected 25 1 0 9 0 1",
                  n, ok, pass_s[2], err_s[2], fv_s[2], fm_s[2]);
      end
   endtask

   task automatic test_restart_ignored();
      int n;
      bit ok;
      clear_faults();
      run(0, 1'b1, n, ok);
      checks++;
      if (n !== 9 || !ok || pass_s[0] !== 1'b1) begin
         errors++;
         $display("FAIL restart_ignored: done %0d seq %0d pass %0d expected 9 1 1", n, ok, pass_s[0]);
      end
   endtask

   task automatic test_back_to_back();
      int first, second;
      clear_faults();
      first = -1;
      second = -1;
      @(negedge clk) start_s[0] = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done_s[0]) begin
            if (first < 0) first = n;
            else begin
               second = n;
               start_s[0] = 1'b0;
               break;
            end
         end
      end
      start_s[0] = 1'b0;
      checks++;
      if (first !== 9 || second !== 19) begin
         errors++;
         $display("FAIL back_to_back: done at %0d,%0d expected 9,19", first, second);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy_s[0] !== 1'b0 || pass_s[0] !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back_stop: busy %0d pass %0d expected 0 1", busy_s[0], pass_s[0]);
      end
   endtask

   task automatic test_midrun_reset();
      int n;
      bit ok, dn;
      clear_faults();
      @(negedge clk) start_s[0] = 1'b1;
      @(posedge clk);
      #1 start_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      checks++;
      if ({a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], fv_s[0], fm_s[0]} !== 23'd0) begin
         errors++;
         $display("FAIL midrun_reset: got %h expected 0", {a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0], err_s[0], fv_s[0], fm_s[0]});
      end
      dn = 1'b0;
      repeat (12) @(negedge clk) dn |= done_s[0];
      checks++;
      if (dn !== 1'b0) begin
         errors++;
         $display("FAIL midrun_no_done: done seen %0d expected 0", dn);
      end
      run(0, 1'b0, n, ok);
      checks++;
      if (n !== 9 || !ok || pass_s[0] !== 1'b1) begin
         errors++;
         $display("FAIL midrun_rerun: done %0d seq %0d pass %0d expected 9 1 1", n, ok, pass_s[0]);
      end
   endtask

   task automatic test_saturate();
      int n;
      bit ok;
      clear_faults();
      for (int v = 0; v < 4; v++) xm[3][v] = 7'h7F;
      run(3, 1'b0, n, ok);
      checks++;
      if (n !== 281 || {pass_s[3], err_s[3], fv_s[3], fm_s[3]} !== {1'b0, 8'd255, 2'b00, 7'h7F}) begin
         errors++;
         $display("FAIL saturate: done %0d pass %0d err %0d fv %0h fm %0h expected 281 0 255 0 7f", n, pass_s[3], err_s[3], fv_s[3], fm_s[3]);
      end
   endtask

   task automatic test_random();
      int n, i, e;
      bit ok;
      logic [1:0] fv;
      logic [6:0] fm;
      for (int t = 0; t < 8; t++) begin
         clear_faults();
         i = $urandom_range(0, 2);
         for (int v = 0; v < 4; v++) xm[i][v] = $urandom_range(0, 1) ? 7'($urandom) : 7'd0;
         s0[i] = $urandom_range(0, 3) == 0 ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
         s1[i] = $urandom_range(0, 3) == 0 ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
         model(i, e, fv, fm);
         run(i, 1'b0, n, ok);
         checks++;
         if (n !== 4 * r_of(i) * s_of(i) + 1 || !ok ||
             {pass_s[i], err_s[i], fv_s[i], fm_s[i]} !== {e == 0, 8'(e), fv, fm}) begin
            errors++;
            $display("FAIL random[%0d] inst %0d: done %0d seq %0d pass %0d err %0d fv %0h fm %0h expected %0d 1 %0d %0d %0h %0h",
                     t, i, n, ok, pass_s[i], err_s[i], fv_s[i], fm_s[i], 4 * r_of(i) * s_of(i) + 1, e == 0, e, fv, fm);
         end
      end
   endtask

   initial begin
      clear_faults();
      test_reset();
      test_golden();
      test_xor_stuck();
      test_lag();
      test_round_stuck();
      test_restart_ignored();
      test_back_to_back();
      test_midrun_reset();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
